// File: rtl/hlsm_pkg.sv
// hlsm_pkg: shared definitions for the HLSM scheduled-datapath kernel.
//   - hlsm_state_t : 3-bit controller state encoding
//   - hlsm_resize  : truncation / saturation of the 2W-bit result
//   - parameter-legality limits used by hlsm_sched_dp
package hlsm_pkg;

  localparam int unsigned W_MIN       = 2;
  localparam int unsigned W_MAX       = 32;
  localparam int unsigned MUL_LAT_MIN = 1;
  localparam int unsigned MUL_LAT_MAX = 4;
  // Working width of the resize helper; covers 2*W_MAX.
  localparam int unsigned RS_W        = 64;

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    FINAL = 3'd1,
    S0    = 3'd2,
    S1    = 3'd3,
    S2    = 3'd4,
    S3    = 3'd5,
    MULW  = 3'd6
  } hlsm_state_t;

  // Returns r unchanged (caller truncates to out_w bits) or, when sat is set,
  // r clamped to the signed out_w-bit range.
  function automatic logic signed [RS_W-1:0] hlsm_resize(
    input logic signed [RS_W-1:0] r,
    input int unsigned            out_w,
    input bit                     sat
  );
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    one = 1;
    hi  = '0;
    lo  = '0;
    if (!sat || out_w >= RS_W) return r;
    hi = (one <<< (out_w - 1)) - one;
    lo = -hi - one;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/hlsm_pipe_mul.sv
// hlsm_pipe_mul: LAT-stage signed W x W -> 2W multiplier.
// Ports:
//   Clk, Rst  : clock, synchronous active-high reset of all stage registers
//   i_launch  : capture i_a*i_b into the first stage
//   i_a, i_b  : signed operands
//   o_p       : exact signed product, valid LAT cycles after launch and held
//               until the next launch has propagated
module hlsm_pipe_mul
  import hlsm_pkg::*;
#(
  parameter int W   = 16,
  parameter int LAT = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  i_launch,
  input  logic signed [W-1:0]   i_a,
  input  logic signed [W-1:0]   i_b,
  output logic signed [2*W-1:0] o_p
);

  localparam int W2 = 2 * W;

  logic signed [W2-1:0] w_a_ext;
  logic signed [W2-1:0] w_b_ext;
  logic signed [W2-1:0] w_prod;
  logic signed [W2-1:0] r_stage [LAT];

  // Full-width product of sign-extended operands is exact in 2W bits.
  assign w_a_ext = W2'(i_a);
  assign w_b_ext = W2'(i_b);
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int unsigned k = 0; k < LAT; k++) r_stage[k] <= '0;
    end else begin
      if (i_launch) r_stage[0] <= w_prod;
      // Later stages shift every cycle; stage 0 holds, so the result persists.
      for (int unsigned k = 1; k < LAT; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_p = r_stage[LAT-1];

endmodule

// File: rtl/hlsm_sched_dp.sv
// hlsm_sched_dp: scheduled-datapath kernel with Start/Done handshake.
//   d = a+b, e = a+c, f = a*c, g = (d > e), z = resize(g ? d : f)
// Ports:
//   Clk, Rst   : clock, synchronous active-high reset
//   Start      : request, sampled only in WAIT
//   a, b, c    : signed W-bit operands, latched at Start
//   Busy       : high whenever the controller is not in WAIT
//   Done       : registered one-cycle result-valid pulse
//   z          : signed OUT_W-bit result, held between operations
// Build option: define HLSM_SATURATE_OUT_EN to clamp z instead of truncating.
module hlsm_sched_dp
  import hlsm_pkg::*;
#(
  parameter int W       = 16,
  parameter int OUT_W   = 8,
  parameter int MUL_LAT = 1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  input  logic signed [W-1:0]     c,
  output logic                    Busy,
  output logic                    Done,
  output logic signed [OUT_W-1:0] z
);

  localparam int W1 = W + 1;
  localparam int W2 = 2 * W;
`ifdef HLSM_SATURATE_OUT_EN
  localparam bit P_SAT = 1'b1;
`else
  localparam bit P_SAT = 1'b0;
`endif

  generate
    if (W < W_MIN || W > W_MAX || OUT_W < 2 || OUT_W > W2 ||
        MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_param
      $error("hlsm_sched_dp: illegal parameter combination");
    end
  endgenerate

  hlsm_state_t          r_state;
  hlsm_state_t          w_next;
  logic signed [W-1:0]  r_a;
  logic signed [W-1:0]  r_b;
  logic signed [W-1:0]  r_c;
  logic signed [W1-1:0] r_d;
  logic signed [W1-1:0] r_e;
  logic signed [W2-1:0] r_f;
  logic                 r_g;
  logic [1:0]           r_cnt;
  logic                 r_done;
  logic signed [OUT_W-1:0] r_z;
  logic signed [W2-1:0] w_prod;
  logic signed [W2-1:0] w_r;
  logic                 w_launch;

  assign w_launch = (r_state == S0);

  hlsm_pipe_mul #(
    .W   (W),
    .LAT (MUL_LAT)
  ) u_mul (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_launch (w_launch),
    .i_a      (r_a),
    .i_b      (r_c),
    .o_p      (w_prod)
  );

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= WAIT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT:    if (Start) w_next = S0;
      S0:      w_next = S1;
      S1:      w_next = (MUL_LAT == 1) ? S2 : MULW;
      MULW:    if (r_cnt == '0) w_next = S2;
      S2:      w_next = S3;
      S3:      w_next = FINAL;
      FINAL:   w_next = WAIT;
      default: w_next = WAIT;
    endcase
  end

  assign w_r = r_g ? W2'(r_d) : r_f;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= '0;
      r_d    <= '0;
      r_e    <= '0;
      r_f    <= '0;
      r_g    <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_z    <= '0;
    end else begin
      r_done <= (r_state == S3);
      case (r_state)
        WAIT: begin
          if (Start) begin
            r_a <= a;
            r_b <= b;
            r_c <= c;
          end
        end
        S0: r_d <= W1'(r_a) + W1'(r_b);
        S1: begin
          r_e <= W1'(r_a) + W1'(r_c);
          // MULW is then held for MUL_LAT-1 cycles (count MUL_LAT-2 down to 0).
          if (MUL_LAT > 1) r_cnt <= 2'(MUL_LAT - 2);
        end
        MULW: if (r_cnt != '0) r_cnt <= r_cnt - 2'd1;
        S2: begin
          r_f <= w_prod;
          r_g <= (r_d > r_e);
        end
        S3: r_z <= OUT_W'(hlsm_resize(RS_W'(w_r), OUT_W, P_SAT));
        default: ;
      endcase
    end
  end

  assign Busy = (r_state != WAIT);
  assign Done = r_done;
  assign z    = r_z;

endmodule

// File: tb/tb_hlsm_sched_dp.sv
module tb_hlsm_sched_dp;

`ifdef HLSM_SATURATE_OUT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start1;
  logic        Start3;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic        Busy1;
  logic        Done1;
  logic [7:0]  z1;
  logic        Busy3;
  logic        Done3;
  logic [7:0]  z3;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  hlsm_sched_dp #(.W(16), .OUT_W(8), .MUL_LAT(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(Start1), .a(a), .b(b), .c(c),
    .Busy(Busy1), .Done(Done1), .z(z1)
  );

  hlsm_sched_dp #(.W(16), .OUT_W(8), .MUL_LAT(3)) dut3 (
    .Clk(Clk), .Rst(Rst), .Start(Start3), .a(a), .b(b), .c(c),
    .Busy(Busy3), .Done(Done3), .z(z3)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation on dut1 from WAIT; checks Busy/Done per cycle and z.
  task automatic run1(input int av, input int bv, input int cv,
                      input logic [7:0] zexp, input string tag);
    logic [7:0] zprev;
    zprev  = z1;
    a      = 16'(av);
    b      = 16'(bv);
    c      = 16'(cv);
    Start1 = 1'b1;
    tick();
    Start1 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check({tag, "_busy"}, 64'(Busy1), 64'(k <= 5));
      check({tag, "_done"}, 64'(Done1), 64'(k == 5));
      if (k < 5)  check({tag, "_zhold"}, 64'(z1), 64'(zprev));
      if (k == 5) check({tag, "_z"}, 64'(z1), 64'(zexp));
      if (k < 6) tick();
    end
  endtask

  initial begin
    int ndone;
    int dc[3];

    Rst = 1'b1; Start1 = 1'b0; Start3 = 1'b0;
    a = '0; b = '0; c = '0;
    tick();
    tick();
    check("rst_busy1", 64'(Busy1), 64'(0));
    check("rst_done1", 64'(Done1), 64'(0));
    check("rst_z1",    64'(z1),    64'(0));
    check("rst_busy3", 64'(Busy3), 64'(0));
    check("rst_z3",    64'(z3),    64'(0));
    Rst = 1'b0;
    tick();

    // d path: d=8, e=5
    run1(3, 5, 2, 8'd8, "trunc_d");
    // product path: f=10000
    run1(100, 0, 100, SAT ? 8'h7F : 8'h10, "mul");
    // negative product: f=-500
    run1(-50, 0, 10, SAT ? 8'h80 : 8'h0C, "neg");
    // negative d selected: d=-5, e=-30
    run1(-10, 5, -20, 8'hFB, "neg_d");
    // full-width add: d=65534, e=-1
    run1(32767, 32767, -32768, SAT ? 8'h7F : 8'hFE, "wide_add");

    // Start while busy ignored; operand change after latch ignored
    a = 16'd3; b = 16'd1; c = 16'd4;
    Start1 = 1'b1;
    tick();
    Start1 = 1'b0;
    a = 16'd9;
    ndone = 0;
    for (int k = 1; k <= 9; k++) begin
      if (Done1) ndone++;
      if (k == 5) check("busy_start_z", 64'(z1), 64'(12));
      Start1 = (k == 2 || k == 4);
      tick();
    end
    check("busy_start_ndone", 64'(ndone), 64'(1));
    check("busy_start_idle",  64'(Busy1), 64'(0));
    check("busy_start_zhold", 64'(z1),    64'(12));

    // Reset in S2 aborts
    a = 16'd3; b = 16'd5; c = 16'd2;
    Start1 = 1'b1;
    tick();
    Start1 = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    tick();
    check("midrst_busy", 64'(Busy1), 64'(0));
    check("midrst_done", 64'(Done1), 64'(0));
    check("midrst_z",    64'(z1),    64'(0));
    Rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (Done1) ndone++;
    end
    check("midrst_nodone", 64'(ndone), 64'(0));

    // Start and Rst together: stays in WAIT
    Rst = 1'b1; Start1 = 1'b1;
    tick();
    check("rst_start_busy", 64'(Busy1), 64'(0));
    Rst = 1'b0; Start1 = 1'b0;
    tick();
    check("rst_start_busy2", 64'(Busy1), 64'(0));
    check("rst_start_done",  64'(Done1), 64'(0));
    run1(3, 5, 2, 8'd8, "after_rst");

    // MUL_LAT=3 single op
    a = 16'd3; b = 16'd1; c = 16'd4;
    Start3 = 1'b1;
    tick();
    Start3 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("lat3_busy", 64'(Busy3), 64'(k <= 7));
      check("lat3_done", 64'(Done3), 64'(k == 7));
      if (k == 7) check("lat3_z", 64'(z3), 64'(12));
      if (k < 8) tick();
    end

    // MUL_LAT=3 with Start held: Done every 8 cycles
    Start3 = 1'b1;
    ndone = 0;
    dc[0] = 0; dc[1] = 0; dc[2] = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (Done3) begin
        if (ndone < 3) dc[ndone] = k;
        ndone++;
      end
    end
    Start3 = 1'b0;
    check("held_ndone", 64'(ndone), 64'(3));
    check("held_d0",    64'(dc[0]), 64'(7));
    check("held_d1",    64'(dc[1]), 64'(15));
    check("held_d2",    64'(dc[2]), 64'(23));
    check("held_z",     64'(z3),    64'(12));
    for (int k = 0; k < 10; k++) tick();
    check("held_idle",  64'(Busy3), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
